multiport_reg_file: RTL and testbench

Parametrised successor to the team's dual-port RAM. Single-clock register file with NUM_RD independent read ports and two byte-enabled write ports (A, B). Adds fixed write-collision priority, optional write-to-read bypass, optional hardwired zero register, and a hardware clear sequencer. Sits in the NewRegFile datapath as the core architectural register store.

---
 rtl/multiport_reg_file_pkg.sv | 20 ++
 rtl/reg_file_clear_seq.sv | 60 ++++++
 rtl/multiport_reg_file.sv | 121 ++++++++++++
 tb/tb_multiport_reg_file.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/multiport_reg_file_pkg.sv
// Shared definitions for the multiport register file: the clear-sequencer
// state encoding and the byte-lane merge helper.
package multiport_reg_file_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int BE_WIDTH       = DATA_WIDTH_DEF / 8;

  // Picks the new byte when its enable is set, otherwise keeps the old one.
  function automatic logic [7:0] lane_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/reg_file_clear_seq.sv
// Clear sequencer: walks every entry once, writing zero, then hands the
// array back to normal traffic. iClear (re)starts the walk at entry 0.
module reg_file_clear_seq
  import multiport_reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iClear,
  output logic                  oBusy,
  output logic                  oClrWe,
  output logic [ADDR_WIDTH-1:0] oClrAddr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (iClear) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        if (iClear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oBusy    = (state_q == ST_CLEAR);
  assign oClrWe   = oBusy;
  assign oClrAddr = cnt_q;

endmodule

// File: rtl/multiport_reg_file.sv
// Architectural register store: NUM_RD registered read ports, two
// byte-enabled write ports with A-over-B lane priority, optional bypass/zero reg.
module multiport_reg_file
  import multiport_reg_file_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH     = 5,
  parameter int NUM_RD         = 2,
  parameter int BYPASS         = 1,
  parameter int ZERO_REG       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                         iClk,
  input  logic                         iRst_n,
  input  logic                         iClear,
  input  logic [NUM_RD-1:0]            iRdEn,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] iRdAddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] oRdData,
  input  logic                         iWrEnA,
  input  logic [ADDR_WIDTH-1:0]        iWrAddrA,
  input  logic [DATA_WIDTH-1:0]        iWrDataA,
  input  logic [DATA_WIDTH/8-1:0]      iWrBeA,
  input  logic                         iWrEnB,
  input  logic [ADDR_WIDTH-1:0]        iWrAddrB,
  input  logic [DATA_WIDTH-1:0]        iWrDataB,
  input  logic [DATA_WIDTH/8-1:0]      iWrBeB,
  output logic                         oBusy,
  output logic                         oCollision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BEW   = DATA_WIDTH / 8;

  logic                  busy, clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  reg_file_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr_seq (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iClear   (iClear),
    .oBusy    (busy),
    .oClrWe   (clr_we),
    .oClrAddr (clr_addr)
  );

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [BEW-1:0]        be_a, be_b;
  logic                  same_addr, wr_a_slot, wr_b_slot;
  logic [DATA_WIDTH-1:0] word_a, word_b;
  logic                  coll_d, coll_q;

  // Effective enables fold in busy and the zero register, so everything
  // downstream (array, bypass) sees only writes that really land.
  always_comb begin
    same_addr = (iWrAddrA == iWrAddrB);
    be_a = (iWrEnA && !busy && !(ZERO_REG != 0 && iWrAddrA == '0)) ? iWrBeA : '0;
    be_b = (iWrEnB && !busy && !(ZERO_REG != 0 && iWrAddrB == '0)) ? iWrBeB : '0;
    wr_a_slot = (|be_a) || (same_addr && (|be_b));
    wr_b_slot = (|be_b) && !same_addr;
    word_a = '0;
    word_b = '0;
    for (int b = 0; b < BEW; b++) begin
      word_a[b*8 +: 8] = lane_merge(
                           lane_merge(mem_q[iWrAddrA][b*8 +: 8], iWrDataB[b*8 +: 8],
                                      same_addr && be_b[b]),
                           iWrDataA[b*8 +: 8], be_a[b]);
      word_b[b*8 +: 8] = lane_merge(mem_q[iWrAddrB][b*8 +: 8], iWrDataB[b*8 +: 8], be_b[b]);
    end
    coll_d = !busy && iWrEnA && iWrEnB && same_addr && (|(iWrBeA & iWrBeB)) &&
             !(ZERO_REG != 0 && iWrAddrA == '0);
  end

  // On a shared address port A's slot carries the merged word for both ports.
  always_ff @(posedge iClk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else begin
      if (wr_a_slot) mem_q[iWrAddrA] <= word_a;
      if (wr_b_slot) mem_q[iWrAddrB] <= word_b;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) coll_q <= 1'b0;
    else         coll_q <= coll_d;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd_word, rd_data_d, rd_data_q;

    assign ra = iRdAddr[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd_word = mem_q[ra];
      if (BYPASS != 0) begin
        if (wr_a_slot && ra == iWrAddrA)      rd_word = word_a;
        else if (wr_b_slot && ra == iWrAddrB) rd_word = word_b;
      end
      if (ZERO_REG != 0 && ra == '0) rd_word = '0;
      rd_data_d = rd_data_q;
      if (busy)          rd_data_d = '0;
      else if (iRdEn[k]) rd_data_d = rd_word;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) rd_data_q <= '0;
      else         rd_data_q <= rd_data_d;
    end

    assign oRdData[k*DATA_WIDTH +: DATA_WIDTH] = rd_data_q;
  end

  assign oBusy      = busy;
  assign oCollision = coll_q;

endmodule

// File: tb/tb_multiport_reg_file.sv
// Directed bench: one bypassing and one non-bypassing register file share
// stimulus; read expectations queue per port and a monitor retires them.
module tb_multiport_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic           iClk, iRst_n, iClear;
  logic [NR-1:0]  rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_bp, rd_nb;
  logic           we_a, we_b;
  logic [AW-1:0]  wa_a, wa_b;
  logic [DW-1:0]  wd_a, wd_b;
  logic [3:0]     be_a, be_b;
  logic           busy_bp, busy_nb, coll_bp, coll_nb;

  multiport_reg_file #(.BYPASS(1)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iClear(iClear),
    .iRdEn(rd_en), .iRdAddr(rd_addr), .oRdData(rd_bp),
    .iWrEnA(we_a), .iWrAddrA(wa_a), .iWrDataA(wd_a), .iWrBeA(be_a),
    .iWrEnB(we_b), .iWrAddrB(wa_b), .iWrDataB(wd_b), .iWrBeB(be_b),
    .oBusy(busy_bp), .oCollision(coll_bp));

  multiport_reg_file #(.BYPASS(0)) dut_nb (
    .iClk(iClk), .iRst_n(iRst_n), .iClear(iClear),
    .iRdEn(rd_en), .iRdAddr(rd_addr), .oRdData(rd_nb),
    .iWrEnA(we_a), .iWrAddrA(wa_a), .iWrDataA(wd_a), .iWrBeA(be_a),
    .iWrEnB(we_b), .iWrAddrB(wa_b), .iWrDataB(wd_b), .iWrBeB(be_b),
    .oBusy(busy_nb), .oCollision(coll_nb));

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct { logic [DW-1:0] bp; logic [DW-1:0] nb; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Read issued at edge N is visible after that edge; retire it on the next negedge.
  logic [NR-1:0] vld_q;
  always @(posedge iClk) vld_q <= rd_en;

  always @(negedge iClk) begin
    exp_t e;
    if (vld_q[0] === 1'b1) begin
      if (q0.size() == 0) chk("sb_underflow0", 32'h1, 32'h0);
      else begin
        e = q0.pop_front();
        chk("rd0_bypass", rd_bp[DW-1:0], e.bp);
        chk("rd0_nobypass", rd_nb[DW-1:0], e.nb);
      end
    end
    if (vld_q[1] === 1'b1) begin
      if (q1.size() == 0) chk("sb_underflow1", 32'h1, 32'h0);
      else begin
        e = q1.pop_front();
        chk("rd1_bypass", rd_bp[2*DW-1:DW], e.bp);
        chk("rd1_nobypass", rd_nb[2*DW-1:DW], e.nb);
      end
    end
  end

  task automatic idle();
    iClear = 1'b0; rd_en = '0; we_a = 1'b0; we_b = 1'b0;
    be_a = '0; be_b = '0;
  endtask

  task automatic cyc();
    @(posedge iClk);
    #1;
    idle();
  endtask

  task automatic wr_a(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    we_a = 1'b1; wa_a = a; wd_a = d; be_a = be;
  endtask

  task automatic wr_b(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    we_b = 1'b1; wa_b = a; wd_b = d; be_b = be;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a,
                    input logic [DW-1:0] bp, input logic [DW-1:0] nb);
    exp_t e;
    e.bp = bp; e.nb = nb;
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = a;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic busy_len(input string nm, input int want);
    int n;
    n = 0;
    while (busy_bp && n < 100) begin cyc(); n++; end
    chk(nm, 32'(n), 32'(want));
    chk({nm, "_nb_done"}, {31'd0, busy_nb}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle();
    wa_a = '0; wa_b = '0; wd_a = '0; wd_b = '0; rd_addr = '0;
    iRst_n = 1'b0;
    #3;
    chk("rst_rddata", rd_bp[DW-1:0] | rd_bp[2*DW-1:DW], 32'h0);
    chk("rst_coll", {31'd0, coll_bp}, 32'h0);
    chk("rst_busy", {31'd0, busy_bp}, 32'h1);
    #20 iRst_n = 1'b1;

    // Initial clear after reset release takes one cycle per entry.
    busy_len("reset_busy_cycles", 32);
    for (int i = 0; i < 32; i++) begin
      rd(0, AW'(i), 32'h0, 32'h0);
      rd(1, AW'(31 - i), 32'h0, 32'h0);
      cyc();
    end

    // Full-word write then read.
    wr_a(5, 32'hDEADBEEF, 4'hF);
    cyc();
    rd(0, 5, 32'hDEADBEEF, 32'hDEADBEEF);
    cyc();

    // Overlapping A/B write: A owns lanes 0-1, B lane 2, lane 3 untouched.
    wr_a(7, 32'h11111111, 4'h3);
    wr_b(7, 32'h22222222, 4'h6);
    rd(1, 7, 32'h00221111, 32'h00000000);
    cyc();
    chk("coll_pulse", {31'd0, coll_bp}, 32'h1);
    chk("coll_pulse_nb", {31'd0, coll_nb}, 32'h1);
    rd(0, 7, 32'h00221111, 32'h00221111);
    cyc();
    chk("coll_once", {31'd0, coll_bp}, 32'h0);
    cyc();
    chk("rd_hold", rd_bp[DW-1:0], 32'h00221111);

    // Same address, disjoint lanes: merged, no collision.
    wr_a(11, 32'hAAAAAAAA, 4'h3);
    wr_b(11, 32'hBBBBBBBB, 4'hC);
    cyc();
    chk("coll_disjoint", {31'd0, coll_bp}, 32'h0);
    rd(0, 11, 32'hBBBBAAAA, 32'hBBBBAAAA);
    cyc();

    // Same-cycle read of a written address: forwarded only with bypass.
    wr_a(9, 32'hCAFEF00D, 4'hF);
    rd(0, 9, 32'hCAFEF00D, 32'h00000000);
    wr_b(10, 32'h12345678, 4'h9);
    rd(1, 10, 32'h12000078, 32'h00000000);
    cyc();
    chk("coll_diff_addr", {31'd0, coll_bp}, 32'h0);
    rd(0, 9, 32'hCAFEF00D, 32'hCAFEF00D);
    rd(1, 10, 32'h12000078, 32'h12000078);
    cyc();

    // Zero register: writes dropped, reads zero, no collision flag.
    wr_a(0, 32'hFFFFFFFF, 4'hF);
    wr_b(0, 32'h55555555, 4'hF);
    rd(0, 0, 32'h0, 32'h0);
    cyc();
    chk("zero_no_coll", {31'd0, coll_bp}, 32'h0);
    rd(1, 0, 32'h0, 32'h0);
    cyc();

    // Clear, then restart it at cnt=10; writes in the window are lost.
    iClear = 1'b1;
    cyc();
    chk("clear_busy", {31'd0, busy_bp}, 32'h1);
    rd(0, 5, 32'h0, 32'h0);
    cyc();
    repeat (9) cyc();
    iClear = 1'b1;
    wr_a(3, 32'h77777777, 4'hF);
    cyc();
    n = 0;
    while (busy_bp && n < 100) begin
      if (n == 2) rd(0, 5, 32'h0, 32'h0);
      if (n == 20) begin
        wr_a(12, 32'h0BADF00D, 4'hF);
        wr_b(12, 32'h0F0F0F0F, 4'hF);
        rd(1, 12, 32'h0, 32'h0);
      end
      cyc();
      if (n == 20) chk("clear_no_coll", {31'd0, coll_bp}, 32'h0);
      n++;
    end
    chk("restart_busy_cycles", 32'(n), 32'd32);
    for (int i = 0; i < 32; i++) begin
      rd(0, AW'(i), 32'h0, 32'h0);
      cyc();
    end

    cyc();
    cyc();
    chk("sb_drain", 32'(q0.size() + q1.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
